tpu_sequencer: RTL and testbench

Host-side controller that sequences the tinytpu core (input_control / systolic / output_control) through one complete matrix operation. It holds the operand bytes written by the host and serializes them onto the core's bit-serial x/y inputs with load_en. It then pulses init, waits for tx_ready, deserializes data_out_z into a result buffer, and raises done with a host acknowledge. It sits between the host register interface and the core, and is the only driver of the core's load_en, init, data_in_x and data_in_y.

---
 rtl/tpu_seq_pkg.sv | 29 ++
 rtl/tpu_seq_piso.sv | 38 +++
 rtl/tpu_sequencer.sv | 159 +++++++++++++++
 tb/tb_tpu_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_seq_pkg.sv
// Shared types and derived constants for the tinytpu host-side sequencer.
package tpu_seq_pkg;

  localparam int unsigned D_W_DEF     = 8;
  localparam int unsigned N_DEF       = 2;
  localparam int unsigned WORD_DEF    = 2;
  localparam int unsigned TIMEOUT_DEF = 255;

  localparam int unsigned LOAD_BITS = N_DEF * WORD_DEF * D_W_DEF;
  localparam int unsigned RES_BITS  = N_DEF * N_DEF * 2 * D_W_DEF;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned LOAD_CNT_W = cnt_w(LOAD_BITS);
  localparam int unsigned RES_CNT_W  = cnt_w(RES_BITS);
  localparam int unsigned WAIT_CNT_W = cnt_w(TIMEOUT_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_e;

endpackage

// File: rtl/tpu_seq_piso.sv
// One operand lane: byte buffer with a host write port, read out MSB first by bit index.
module tpu_seq_piso #(
  parameter int unsigned D_W   = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]         wr_addr_i,
  input  logic [D_W-1:0]                   wr_data_i,
  input  logic [$clog2(DEPTH*D_W)-1:0]     bit_idx_i,
  output logic                             bit_o
);

  localparam int unsigned BW = $clog2(D_W);
  localparam int unsigned IW = $clog2(DEPTH * D_W);

  logic [D_W-1:0]           mem_q [DEPTH];
  logic [D_W-1:0]           mem_d [DEPTH];
  logic [$clog2(DEPTH)-1:0] byte_sel;
  logic [BW-1:0]            bit_sel;

  // Serial bit is taken from the post-write image so a write in the start cycle feeds bit 0.
  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) mem_d[wr_addr_i] = wr_data_i;
  end

  assign byte_sel = bit_idx_i[IW-1:BW];
  assign bit_sel  = ~bit_idx_i[BW-1:0];
  assign bit_o    = mem_d[byte_sel][bit_sel];

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

endmodule

// File: rtl/tpu_sequencer.sv
// Sequences the tinytpu core: serial operand load, init, result wait with timeout, capture, done/ack.
module tpu_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int unsigned D_W     = D_W_DEF,
  parameter int unsigned N       = N_DEF,
  parameter int unsigned WORD    = WORD_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(N*WORD)-1:0]   wr_addr,
  input  logic [D_W-1:0]              wr_data_x,
  input  logic [D_W-1:0]              wr_data_y,
  input  logic                        start,
  input  logic                        ack,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  input  logic [$clog2(N*N)-1:0]      rd_addr,
  output logic [2*D_W-1:0]            rd_data,
  output logic                        tpu_data_in_x,
  output logic                        tpu_data_in_y,
  output logic                        tpu_load_en,
  output logic                        tpu_init,
  input  logic                        tpu_data_out_z,
  input  logic                        tpu_tx_ready
);

  localparam int unsigned LD_BITS = N * WORD * D_W;
  localparam int unsigned RS_BITS = N * N * 2 * D_W;
  localparam int unsigned LD_W    = cnt_w(LD_BITS);
  localparam int unsigned RS_W    = cnt_w(RS_BITS);
  localparam int unsigned WT_W    = cnt_w(TIMEOUT);
  localparam int unsigned IDX_W   = $clog2(LD_BITS);
  localparam int unsigned E_W     = 2 * D_W;

  state_e             state_q, state_d;
  logic [LD_W-1:0]    ld_cnt_q, ld_cnt_d;
  logic [RS_W-1:0]    rs_cnt_q, rs_cnt_d;
  logic [WT_W-1:0]    wt_cnt_q, wt_cnt_d;
  logic [RS_BITS-1:0] res_q, res_d;
  logic               busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic               load_q, load_d, init_q, init_d, x_q, x_d, y_q, y_d;
  logic               timeout_hit, buf_we, x_bit, y_bit;
  logic [IDX_W-1:0]   bit_idx;
  logic [E_W-1:0]     elem [N*N];

  assign buf_we  = wr_en && (state_q == S_IDLE);
  assign bit_idx = (state_q == S_LOAD) ? ld_cnt_q[IDX_W-1:0] : '0;

  tpu_seq_piso #(.D_W(D_W), .DEPTH(N*WORD)) u_lane_x (
    .clk(clk), .rst(rst), .wr_en_i(buf_we), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data_x), .bit_idx_i(bit_idx), .bit_o(x_bit)
  );

  tpu_seq_piso #(.D_W(D_W), .DEPTH(N*WORD)) u_lane_y (
    .clk(clk), .rst(rst), .wr_en_i(buf_we), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data_y), .bit_idx_i(bit_idx), .bit_o(y_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ld_cnt_q <= '0;
      rs_cnt_q <= '0;
      wt_cnt_q <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      load_q   <= 1'b0;
      init_q   <= 1'b0;
      x_q      <= 1'b0;
      y_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      rs_cnt_q <= rs_cnt_d;
      wt_cnt_q <= wt_cnt_d;
      res_q    <= res_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      load_q   <= load_d;
      init_q   <= init_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  // Bit 0 of the load is emitted on the start edge, so the load counter leaves IDLE at 1.
  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    rs_cnt_d    = rs_cnt_q;
    wt_cnt_d    = wt_cnt_q;
    res_d       = res_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_LOAD;
        ld_cnt_d = LD_W'(1);
      end
      S_LOAD: begin
        if (ld_cnt_q == LD_W'(LD_BITS)) state_d = S_START;
        else                            ld_cnt_d = ld_cnt_q + 1'b1;
      end
      S_START: begin
        state_d  = S_WAIT;
        wt_cnt_d = '0;
      end
      S_WAIT: begin
        if (tpu_tx_ready) begin
          state_d  = S_CAPTURE;
          res_d    = {res_q[RS_BITS-2:0], tpu_data_out_z};
          rs_cnt_d = RS_W'(1);
        end else if (wt_cnt_q == WT_W'(TIMEOUT - 1)) begin
          state_d     = S_DONE;
          timeout_hit = 1'b1;
        end else begin
          wt_cnt_d = wt_cnt_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        res_d = {res_q[RS_BITS-2:0], tpu_data_out_z};
        if (rs_cnt_q == RS_W'(RS_BITS - 1)) state_d = S_DONE;
        else                                rs_cnt_d = rs_cnt_q + 1'b1;
      end
      S_DONE: if (ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d  = (state_d != S_IDLE);
    load_d  = (state_d == S_LOAD);
    init_d  = (state_d == S_START);
    x_d     = load_d & x_bit;
    y_d     = load_d & y_bit;
    done_d  = (state_d == S_DONE);
    error_d = done_d && ((state_q == S_DONE) ? error_q : timeout_hit);
  end

  for (genvar e = 0; e < N*N; e++) begin : g_elem
    assign elem[e] = res_q[RS_BITS-1-e*E_W -: E_W];
  end

  assign rd_data       = elem[rd_addr];
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign tpu_load_en   = load_q;
  assign tpu_init      = init_q;
  assign tpu_data_in_x = x_q;
  assign tpu_data_in_y = y_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed bench for tpu_sequencer with a bit-level operand model and a result scoreboard.
module tb_tpu_sequencer;
  import tpu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, wr_en, start, ack, tpu_data_out_z, tpu_tx_ready;
  logic [1:0]  wr_addr, rd_addr;
  logic [7:0]  wr_data_x, wr_data_y;
  logic        busy, done, error, tpu_data_in_x, tpu_data_in_y, tpu_load_en, tpu_init;
  logic [15:0] rd_data;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  xb [4];
  logic [7:0]  yb [4];
  logic        qx [$];
  logic        qy [$];
  logic [15:0] rq [$];

  tpu_sequencer #(.D_W(8), .N(2), .WORD(2), .TIMEOUT(TIMEOUT_DEF)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data_x(wr_data_x), .wr_data_y(wr_data_y), .start(start), .ack(ack),
    .busy(busy), .done(done), .error(error), .rd_addr(rd_addr), .rd_data(rd_data),
    .tpu_data_in_x(tpu_data_in_x), .tpu_data_in_y(tpu_data_in_y),
    .tpu_load_en(tpu_load_en), .tpu_init(tpu_init),
    .tpu_data_out_z(tpu_data_out_z), .tpu_tx_ready(tpu_tx_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
    chk({tag, "_load_en"}, tpu_load_en, 1'b0);
    chk({tag, "_init"}, tpu_init, 1'b0);
    chk({tag, "_x"}, tpu_data_in_x, 1'b0);
    chk({tag, "_y"}, tpu_data_in_y, 1'b0);
  endtask

  task automatic read_results(input string tag);
    for (int e = 0; e < 4; e++) begin
      rd_addr = 2'(e);
      #1;
      if (rq.size() == 0) chk({tag, "_rq_empty"}, 1'b1, 1'b0);
      else                chk({tag, "_rd"}, rd_data, rq.pop_front());
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] x, input logic [7:0] y);
    wr_en = 1'b1; wr_addr = a; wr_data_x = x; wr_data_y = y;
    xb[a] = x; yb[a] = y;
    step();
    wr_en = 1'b0;
  endtask

  task automatic push_stream();
    for (int b = 0; b < 4; b++)
      for (int i = 7; i >= 0; i--) begin
        qx.push_back(xb[b][i]);
        qy.push_back(yb[b][i]);
      end
  endtask

  task automatic start_op();
    push_stream();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called on the first load cycle; disturb >= 0 pulses start+write to byte 1 during LOAD.
  task automatic check_load(input string tag, input int disturb);
    for (int k = 0; k < LOAD_BITS; k++) begin
      chk({tag, "_load_en"}, tpu_load_en, 1'b1);
      chk({tag, "_init_low"}, tpu_init, 1'b0);
      if (qx.size() == 0) chk({tag, "_qx_empty"}, 1'b1, 1'b0);
      else                chk({tag, "_x_bit"}, tpu_data_in_x, qx.pop_front());
      if (qy.size() == 0) chk({tag, "_qy_empty"}, 1'b1, 1'b0);
      else                chk({tag, "_y_bit"}, tpu_data_in_y, qy.pop_front());
      if (k == disturb) begin
        wr_en = 1'b1; wr_addr = 2'd1; wr_data_x = 8'h00; wr_data_y = 8'h00; start = 1'b1;
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      step();
    end
    wr_en = 1'b0; start = 1'b0;
    chk({tag, "_load_end"}, tpu_load_en, 1'b0);
    chk({tag, "_init"}, tpu_init, 1'b1);
    chk({tag, "_x_quiet"}, tpu_data_in_x, 1'b0);
    chk({tag, "_y_quiet"}, tpu_data_in_y, 1'b0);
  endtask

  // Core model: tx_ready after 'delay' WAIT cycles, then 64 result bits MSB first.
  task automatic capture(input string tag, input logic [63:0] val, input int delay);
    for (int d = 0; d < delay; d++) begin
      tpu_tx_ready = 1'b0;
      step();
      chk({tag, "_init_once"}, tpu_init, 1'b0);
      chk({tag, "_wait_done"}, done, 1'b0);
    end
    for (int e = 0; e < 4; e++) rq.push_back(val[63-16*e -: 16]);
    for (int i = 0; i < RES_BITS; i++) begin
      tpu_tx_ready   = (i < 8);
      tpu_data_out_z = val[63-i];
      step();
      if (i == RES_BITS - 2) chk({tag, "_done_early"}, done, 1'b0);
    end
    tpu_tx_ready = 1'b0; tpu_data_out_z = 1'b0;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_error"}, error, 1'b0);
    chk({tag, "_busy"}, busy, 1'b1);
    read_results(tag);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk({tag, "_done_clr"}, done, 1'b0);
    chk({tag, "_error_clr"}, error, 1'b0);
    chk({tag, "_busy_clr"}, busy, 1'b0);
  endtask

  task automatic timeout_op(input string tag);
    tpu_tx_ready = 1'b0;
    for (int k = 0; k < TIMEOUT_DEF; k++) step();
    chk({tag, "_done_early"}, done, 1'b0);
    step();
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_error"}, error, 1'b1);
    for (int e = 0; e < 4; e++) rq.push_back(16'h0000);
    read_results(tag);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; start = 1'b0; ack = 1'b0; wr_addr = '0; rd_addr = '0;
    wr_data_x = '0; wr_data_y = '0; tpu_data_out_z = 1'b0; tpu_tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin xb[i] = '0; yb[i] = '0; end
    step(); step();
    chk_idle_outputs("reset");
    for (int e = 0; e < 4; e++) rq.push_back(16'h0000);
    read_results("reset");
    rst = 1'b0;
    step();

    // 1 + 2: nominal load and capture
    wr(2'd0, 8'h01, 8'h10); wr(2'd1, 8'h02, 8'h20);
    wr(2'd2, 8'h03, 8'h30); wr(2'd3, 8'h04, 8'h40);
    start_op();
    check_load("t1", -1);
    capture("t2", 64'h0001_0002_0003_0004, 5);
    do_ack("t2");

    // 5: reset mid-capture, then a clean operation that times out (3)
    start_op();
    check_load("t5load", -1);
    for (int i = 0; i < 20; i++) begin
      tpu_tx_ready = 1'b1; tpu_data_out_z = i[0];
      step();
    end
    rst = 1'b1; tpu_tx_ready = 1'b0; tpu_data_out_z = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin xb[i] = '0; yb[i] = '0; end
    chk_idle_outputs("t5");
    for (int e = 0; e < 4; e++) rq.push_back(16'h0000);
    read_results("t5");
    wr(2'd1, 8'hA5, 8'h3C); wr(2'd3, 8'h81, 8'h7E);
    start_op();
    check_load("t3load", -1);
    timeout_op("t3");
    do_ack("t3");

    // 4: write and start in the same cycle, disturbance during LOAD
    wr_en = 1'b1; wr_addr = 2'd0; wr_data_x = 8'hFF; wr_data_y = 8'h5A; start = 1'b1;
    xb[0] = 8'hFF; yb[0] = 8'h5A;
    push_stream();
    step();
    wr_en = 1'b0; start = 1'b0;
    check_load("t4", 3);
    capture("t4", 64'hBEEF_1234_8001_7FFE, 2);

    // 6: long-held DONE ignores start and wr_en
    for (int k = 0; k < 20; k++) begin
      ack = 1'b0; start = (k % 3 == 0); wr_en = (k == 5); wr_addr = 2'd2;
      wr_data_x = 8'hAA; wr_data_y = 8'hBB;
      step();
      chk("t6_done_hold", done, 1'b1);
      chk("t6_busy_hold", busy, 1'b1);
    end
    start = 1'b0; wr_en = 1'b0;
    do_ack("t6");
    step();
    chk("t6_stay_idle", busy, 1'b0);
    start_op();
    check_load("t6buf", -1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_outputs("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
